fifo_stream_reader: RTL

Read-side adapter sitting directly downstream of the team's synchronous FIFO. It drives the FIFO's read enable, absorbs the FIFO's one-cycle registered read latency, and presents the words on a valid/ready stream port with full throughput and no loss under arbitrary back-pressure. It also keeps a running count of delivered beats for debug and performance counters.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/stream_skid_buf.sv | 66 ++++++
 rtl/fifo_stream_reader.sv | 65 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and types for the synchronous FIFO and its read-side adapter
// Contents: FIFO_WIDTH (data word width shared with the FIFO), BEAT_CNT_W (beat counter width),
// occ_t (output buffer occupancy 0..2).
package fifo_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int BEAT_CNT_W = 32;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - two-entry in-order buffer feeding a valid/ready stream
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   push, push_data  write a word at the tail this cycle
//   pop              remove the head word this cycle (only while valid)
//   occ              number of stored words (0..2), registered
//   valid            occ != 0, registered
//   head             oldest stored word, registered; 0 after reset
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] tail;
    occ_t             next_occ;

    always_comb begin
        next_occ = occ;
        case ({push, pop})
            2'b10:   next_occ = occ + 2'd1;
            2'b01:   next_occ = occ - 2'd1;
            default: next_occ = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ   <= '0;
            valid <= 1'b0;
            head  <= '0;
            tail  <= '0;
        end else begin
            occ   <= next_occ;
            valid <= (next_occ != 2'd0);
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= push_data;
                    else             tail <= push_data;
                end
                2'b01: head <= tail;
                2'b11: begin
                    // With one word stored the incoming word becomes the head
                    // directly; with two, it shifts in behind the old tail.
                    if (occ == 2'd2) begin
                        head <= tail;
                        tail <= push_data;
                    end else begin
                        head <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side adapter: issues reads, absorbs read latency, drives a valid/ready stream
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   fifo_empty   upstream FIFO empty flag
//   fifo_rd_en   upstream FIFO read enable (combinational)
//   fifo_data    upstream registered read data, valid the cycle after a read
//   m_valid      output word valid (registered)
//   m_ready      downstream accept
//   m_data       output word (registered)
//   beat_count   completed output handshakes since reset, wraps
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int CNT_W = BEAT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] beat_count
);

    occ_t       occ;
    logic       inflight;
    logic       pop;
    logic [1:0] committed;

    assign pop = m_valid & m_ready;

    // Words already owned by the adapter: stored plus the one arriving now.
    // A read may be issued at two committed words only if a pop frees a slot
    // in the same cycle, which keeps full throughput out of a stall.
    assign committed  = occ + {1'b0, inflight};
    assign fifo_rd_en = rst_n & ~fifo_empty &
                        ((committed < 2'd2) | ((committed == 2'd2) & pop));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight   <= 1'b0;
            beat_count <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) beat_count <= beat_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .valid     (m_valid),
        .head      (m_data)
    );

endmodule
